// File: rtl/mem_ctrl_mp.sv
`timescale 1ns/1ps
// mem_ctrl_mp: multi-port byte-serial memory controller.
// Arbitrates NPORT requesters onto an 8-bit RAM port, one transaction at a
// time. Reads assemble little-endian bytes with optional sign extension.
// Writes stall on IO addresses while the UART buffer is full.
module mem_ctrl_mp #(
  parameter int               NPORT      = 3,
  parameter int               DATA_W     = 32,
  parameter int               ARB_RR     = 0,
  parameter logic [NPORT-1:0] FLUSH_MASK = {NPORT{1'b1}},
  parameter logic [31:0]      IO_BASE    = 32'h30000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic [NPORT-1:0]        req_valid,
  input  logic [NPORT-1:0]        req_we,
  input  logic [NPORT*32-1:0]     req_addr,
  input  logic [NPORT*2-1:0]      req_size,
  input  logic [NPORT-1:0]        req_signed,
  input  logic [NPORT*DATA_W-1:0] req_wdata,
  output logic [NPORT-1:0]        resp_valid,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    busy,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  localparam int NB = DATA_W / 8;
  localparam int IW = $clog2(NB) + 1;            // byte index must reach NB
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       port_q, port_d, rr_q, rr_d;
  logic                we_q, we_d, sgn_q, sgn_d;
  logic [31:0]         addr_q, addr_d, mem_a_q, mem_a_d;
  logic [1:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rbuf_q, rbuf_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [NPORT-1:0]    resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                mem_wr_q, mem_wr_d;

  // A masked read is not eligible while flush is high; writes always are.
  logic [NPORT-1:0] elig;
  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_elig
      assign elig[gi] = req_valid[gi] && !(flush && FLUSH_MASK[gi] && !req_we[gi]);
    end
  endgenerate

  // Pick one eligible port: from 0 (fixed) or from the port after the last grant.
  logic          gnt_found;
  logic [PW-1:0] gnt;
  int            base;
  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    base      = (ARB_RR != 0) ? ((int'(rr_q) + 1) % NPORT) : 0;
    for (int off = 0; off < NPORT; off++) begin
      if (!gnt_found && elig[(base + off) % NPORT]) begin
        gnt_found = 1'b1;
        gnt       = PW'((base + off) % NPORT);
      end
    end
  end

  logic [31:0]       g_addr;
  logic [1:0]        g_size;
  logic [DATA_W-1:0] g_wdata;
  assign g_addr  = req_addr[int'(gnt)*32 +: 32];
  assign g_size  = req_size[int'(gnt)*2 +: 2];
  assign g_wdata = req_wdata[int'(gnt)*DATA_W +: DATA_W];

  function automatic logic is_io(input logic [31:0] a);
    return (a == IO_BASE) || (a == IO_BASE + 32'd4);
  endfunction

  logic [IW-1:0]     nbytes, idx_next;
  logic [DATA_W-1:0] ext_mask, rd_merged;
  logic              sign_bit, io_stall;
  assign nbytes    = IW'(1) << size_q;
  assign idx_next  = idx_q + IW'(1);
  assign ext_mask  = {DATA_W{1'b1}} << {nbytes, 3'b000};
  assign sign_bit  = 1'(rbuf_q >> (8 * int'(nbytes) - 1));
  assign rd_merged = rbuf_q | (DATA_W'(mem_din) << {idx_q, 3'b000});
  assign io_stall  = is_io(addr_q) && io_buffer_full;

  // Next-state and output logic for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    rr_d         = rr_q;
    we_d         = we_q;
    sgn_d        = sgn_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    idx_d        = idx_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          port_d  = gnt;
          rr_d    = gnt;
          we_d    = req_we[gnt];
          sgn_d   = req_signed[gnt];
          addr_d  = g_addr;
          size_d  = g_size;
          wdata_d = g_wdata;
          idx_d   = '0;
          rbuf_d  = '0;
          mem_a_d = g_addr;
          if (req_we[gnt]) begin
            state_d    = WRITE;
            mem_dout_d = g_wdata[7:0];
            mem_wr_d   = !(is_io(g_addr) && io_buffer_full);
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (flush && FLUSH_MASK[port_q]) begin
          state_d = TURN;
          mem_a_d = '0;
        end else if (idx_q < nbytes) begin
          rbuf_d  = rd_merged;
          idx_d   = idx_next;
          mem_a_d = (idx_next < nbytes) ? addr_q + 32'(idx_next) : '0;
        end else begin
          resp_valid_d[port_q] = 1'b1;
          resp_data_d = (sgn_q && sign_bit) ? (rbuf_q | ext_mask) : rbuf_q;
          state_d     = TURN;
          mem_a_d     = '0;
        end
      end
      WRITE: begin
        if (!mem_wr_q) begin
          // Stalled on a full IO buffer: retry the same byte.
          mem_wr_d = !io_stall;
        end else if (idx_next < nbytes) begin
          idx_d      = idx_next;
          mem_a_d    = addr_q + 32'(idx_next);
          mem_dout_d = 8'(wdata_q >> {idx_next, 3'b000});
          mem_wr_d   = !io_stall;
        end else begin
          mem_wr_d             = 1'b0;
          mem_a_d              = '0;
          resp_valid_d[port_q] = 1'b1;
          state_d              = TURN;
        end
      end
      default: begin  // TURN
        state_d  = IDLE;
        mem_wr_d = 1'b0;
        mem_a_d  = '0;
      end
    endcase
  end

  // State register: reset wins over rdy; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      port_q       <= '0;
      rr_q         <= PW'(NPORT - 1);
      we_q         <= 1'b0;
      sgn_q        <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      rbuf_q       <= '0;
      idx_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
    end else if (rdy) begin
      state_q      <= state_d;
      port_q       <= port_d;
      rr_q         <= rr_d;
      we_q         <= we_d;
      sgn_q        <= sgn_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      idx_q        <= idx_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q;
  assign busy       = (state_q == READ) || (state_q == WRITE);

endmodule

// File: tb/tb_mem_ctrl_mp.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_ctrl_mp: stimulus pushes expected responses and
// RAM writes into queues; negedge monitors pop and compare.
module tb_mem_ctrl_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, flush, io_full;
  logic [2:0]  req_valid, req_we, req_signed;
  logic [95:0] req_addr, req_wdata;
  logic [5:0]  req_size;
  logic [2:0]  resp_valid;
  logic [31:0] resp_data, mem_a;
  logic        busy, mem_wr;
  logic [7:0]  mem_din, mem_dout;
  logic [7:0]  ram [0:4095];
  assign mem_din = ram[mem_a[11:0]];

  mem_ctrl_mp dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_full));

  // Round-robin instance: three 1-byte reads; RAM returns addr ^ 0x5A.
  logic [2:0]  rr_valid, rr_resp;
  logic [31:0] rr_data, rr_a;
  logic        rr_busy, rr_wr;
  logic [7:0]  rr_dout, rr_din;
  assign rr_din = rr_a[7:0] ^ 8'h5A;

  mem_ctrl_mp #(.ARB_RR(1)) dut_rr (
    .clk(clk), .rst(rst), .rdy(1'b1), .flush(1'b0),
    .req_valid(rr_valid), .req_we(3'b000), .req_addr({32'h30, 32'h20, 32'h10}),
    .req_size(6'b0), .req_signed(3'b000), .req_wdata(96'h0),
    .resp_valid(rr_resp), .resp_data(rr_data), .busy(rr_busy),
    .mem_din(rr_din), .mem_dout(rr_dout), .mem_a(rr_a), .mem_wr(rr_wr),
    .io_buffer_full(1'b0));

  int n_checks = 0, n_errors = 0;

  typedef struct {int port; logic [31:0] data; bit chk_data; int lat;} exp_t;
  typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;
  exp_t sb_q[$];
  exp_t rr_q[$];
  wr_t  wr_q[$];
  exp_t m_e, r_e;
  wr_t  m_w;
  int   rem[3];
  int   busy_cnt = 0;
  int   rr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input int p, input bit we, input logic [31:0] a, input logic [1:0] sz,
                       input bit sg, input logic [31:0] wd, input int cnt);
    req_we[p]              = we;
    req_addr[p*32 +: 32]   = a;
    req_size[p*2 +: 2]     = sz;
    req_signed[p]          = sg;
    req_wdata[p*32 +: 32]  = wd;
    rem[p]                 = cnt;
    req_valid[p]           = 1'b1;
  endtask

  task automatic exp_resp(input int p, input logic [31:0] d, input bit cd, input int lat);
    exp_t e;
    e.port = p; e.data = d; e.chk_data = cd; e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a; w.d = d;
    wr_q.push_back(w);
  endtask

  task automatic wait_done(input string name, input int maxc);
    int c = 0;
    bit done = 1'b0;
    while (!done && c < maxc) begin
      @(negedge clk);
      c++;
      done = (req_valid == 3'b000) && (sb_q.size() == 0) && (wr_q.size() == 0) && !busy;
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL %s_timeout: got not done after %0d cycles, expected done", name, c);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_busy(input string name, input int maxc);
    int c = 0;
    while (!busy && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_busy"}, {31'b0, busy}, 32'd1);
  endtask

  // Main monitor: responses, RAM writes, IO-stall rule, busy-cycle latency.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid != 3'b000) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_resp: got resp_valid=%b, expected none", resp_valid);
        end else begin
          m_e = sb_q.pop_front();
          $display("resp port %0d data 0x%08h busy_cycles %0d", m_e.port, resp_data, busy_cnt);
          chk($sformatf("resp_onehot_p%0d", m_e.port), {29'b0, resp_valid}, 32'(1 << m_e.port));
          if (m_e.chk_data) chk($sformatf("resp_data_p%0d", m_e.port), resp_data, m_e.data);
          if (m_e.lat >= 0) chk($sformatf("latency_p%0d", m_e.port), busy_cnt, m_e.lat);
          chk("turn_mem_a", mem_a, 32'h0);
          chk("turn_wr_busy", {30'b0, mem_wr, busy}, 32'h0);
        end
        for (int p = 0; p < 3; p++) begin
          if (resp_valid[p]) begin
            rem[p]--;
            if (rem[p] <= 0) req_valid[p] = 1'b0;
          end
        end
      end
      if (mem_wr && rdy) begin
        if (wr_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_write: got 0x%02h@0x%08h, expected no write", mem_dout, mem_a);
        end else begin
          m_w = wr_q.pop_front();
          $display("write 0x%02h @ 0x%08h", mem_dout, mem_a);
          chk("write_addr", mem_a, m_w.a);
          chk("write_data", {24'b0, mem_dout}, {24'b0, m_w.d});
        end
        ram[mem_a[11:0]] = mem_dout;
      end
      if (mem_wr && io_full) begin
        n_checks++; n_errors++;
        $display("FAIL io_stall_write: got mem_wr=1 at 0x%08h, expected 0 while buffer full", mem_a);
      end
      busy_cnt = busy ? busy_cnt + 1 : 0;
    end
  end

  // Round-robin monitor: grant order and data; stops requests after four.
  always @(negedge clk) begin
    if (!rst) begin
      if (rr_wr) begin
        n_checks++; n_errors++;
        $display("FAIL rr_mem_wr: got 1, expected 0");
      end
      if (rr_resp != 3'b000) begin
        if (rr_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rr_unexpected_resp: got %b, expected none", rr_resp);
        end else begin
          r_e = rr_q.pop_front();
          $display("rr resp port %0d data 0x%08h", r_e.port, rr_data);
          chk($sformatf("rr_grant_%0d", rr_cnt), {29'b0, rr_resp}, 32'(1 << r_e.port));
          chk($sformatf("rr_data_%0d", rr_cnt), rr_data, r_e.data);
        end
        rr_cnt++;
        if (rr_cnt == 4) rr_valid = 3'b000;
      end
    end
  end

  initial begin
    exp_t e;
    int c;
    rst = 1'b1; rdy = 1'b0; flush = 1'b0; io_full = 1'b0;
    req_valid = '0; req_we = '0; req_signed = '0; req_addr = '0; req_size = '0; req_wdata = '0;
    rr_valid = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    repeat (2) @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    chk("rst_resp_valid", {29'b0, resp_valid}, 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr_busy", {30'b0, mem_wr, busy}, 32'h0);
    chk("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
    chk("rst_rr", {rr_data[15:0], 5'b0, rr_resp, rr_dout[6:0], rr_busy}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // LW port 1 from 0x100
    ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
    issue(1, 0, 32'h100, 2, 0, 0, 1); exp_resp(1, 32'h12345678, 1, 5);
    wait_done("lw", 40);

    // LB signed / unsigned from 0x80
    ram[12'h110] = 8'h80;
    issue(0, 0, 32'h110, 0, 1, 0, 1); exp_resp(0, 32'hFFFFFF80, 1, 2);
    wait_done("lb_s", 40);
    issue(2, 0, 32'h110, 0, 0, 0, 1); exp_resp(2, 32'h00000080, 1, 2);
    wait_done("lb_u", 40);

    // LH signed
    ram[12'h120] = 8'h34; ram[12'h121] = 8'h92;
    issue(0, 0, 32'h120, 1, 1, 0, 1); exp_resp(0, 32'hFFFF9234, 1, 3);
    wait_done("lh_s", 40);

    // SH 0xBEEF to 0x200, then read back
    issue(0, 1, 32'h200, 1, 0, 32'h0000BEEF, 1);
    exp_wr(32'h200, 8'hEF); exp_wr(32'h201, 8'hBE); exp_resp(0, 0, 0, 2);
    wait_done("sh", 40);
    issue(1, 0, 32'h200, 1, 0, 0, 1); exp_resp(1, 32'h0000BEEF, 1, 3);
    wait_done("sh_rb", 40);

    // SW and signed full-width read back
    issue(1, 1, 32'h300, 2, 0, 32'hCAFEF00D, 1);
    exp_wr(32'h300, 8'h0D); exp_wr(32'h301, 8'hF0); exp_wr(32'h302, 8'hFE); exp_wr(32'h303, 8'hCA);
    exp_resp(1, 0, 0, 4);
    wait_done("sw", 40);
    issue(2, 0, 32'h300, 2, 1, 0, 1); exp_resp(2, 32'hCAFEF00D, 1, 5);
    wait_done("sw_rb", 40);

    // IO write stalled 5 cycles, concurrent read from port 1 waits
    io_full = 1'b1;
    issue(0, 1, 32'h30000, 0, 0, 32'h000000A5, 1);
    issue(1, 0, 32'h110, 0, 0, 0, 1);
    exp_wr(32'h30000, 8'hA5); exp_resp(0, 0, 0, 6); exp_resp(1, 32'h00000080, 1, 2);
    repeat (5) @(negedge clk);
    io_full = 1'b0;
    wait_done("io", 60);

    // Fixed priority: port 0 keeps winning while it requests
    issue(0, 0, 32'h110, 0, 0, 0, 2);
    issue(1, 0, 32'h120, 0, 0, 0, 1);
    issue(2, 0, 32'h121, 0, 1, 0, 1);
    exp_resp(0, 32'h80, 1, 2); exp_resp(0, 32'h80, 1, 2);
    exp_resp(1, 32'h34, 1, 2); exp_resp(2, 32'hFFFFFF92, 1, 2);
    wait_done("fixed", 80);

    // Flush on 2nd byte of port-0 LW; pending port-2 SW proceeds
    issue(0, 0, 32'h100, 2, 0, 0, 1);
    issue(2, 1, 32'h400, 2, 0, 32'h11223344, 1);
    exp_wr(32'h400, 8'h44); exp_wr(32'h401, 8'h33); exp_wr(32'h402, 8'h22); exp_wr(32'h403, 8'h11);
    exp_resp(2, 0, 0, 4);
    wait_busy("flush", 10);
    chk("flush_byte0_addr", mem_a, 32'h100);
    @(negedge clk);
    chk("flush_byte1_addr", mem_a, 32'h101);
    flush = 1'b1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("flush_abort_busy", {31'b0, busy}, 32'h0);
    chk("flush_abort_mem_a", mem_a, 32'h0);
    flush = 1'b0;
    wait_done("flush", 60);
    issue(1, 0, 32'h400, 2, 0, 0, 1); exp_resp(1, 32'h11223344, 1, 5);
    wait_done("flush_rb", 40);

    // rdy low for two edges mid-read
    issue(1, 0, 32'h110, 0, 1, 0, 1); exp_resp(1, 32'hFFFFFF80, 1, 4);
    wait_busy("rdy", 10);
    rdy = 1'b0;
    @(negedge clk);
    chk("rdy_hold_mem_a", mem_a, 32'h110);
    chk("rdy_hold_busy", {31'b0, busy}, 32'h1);
    @(negedge clk);
    rdy = 1'b1;
    wait_done("rdy", 40);

    // Round-robin order 0,1,2,0
    e.chk_data = 1; e.lat = -1;
    e.port = 0; e.data = 32'h4A; rr_q.push_back(e);
    e.port = 1; e.data = 32'h7A; rr_q.push_back(e);
    e.port = 2; e.data = 32'h6A; rr_q.push_back(e);
    e.port = 0; e.data = 32'h4A; rr_q.push_back(e);
    rr_valid = 3'b111;
    c = 0;
    while (rr_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("rr_all_done", 32'(rr_q.size()), 32'h0);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_ctrl_mp.md
MEM_CTRL_MP -- requirements
Module: mem_ctrl_mp

Interface
REQ-001 SHALL have parameter NPORT, default 3: number of requester ports.
REQ-002 SHALL have parameter DATA_W, default 32: request data width, a multiple of 8; NB = DATA_W/8 bytes.
REQ-003 SHALL have parameter ARB_RR, default 0: 0 = fixed priority (lower index wins), 1 = round-robin.
REQ-004 SHALL have parameter FLUSH_MASK, default {NPORT{1'b1}}: ports whose reads are cancelled by flush.
REQ-005 SHALL have parameter IO_BASE, default 32'h30000: IO-mapped write addresses are IO_BASE and IO_BASE+4.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port rdy, input, 1: global enable; when low, all state holds.
REQ-009 SHALL have port flush, input, 1: misprediction flush.
REQ-010 SHALL have port req_valid, input, NPORT: per-port request.
REQ-011 SHALL have port req_we, input, NPORT: 1 = write.
REQ-012 SHALL have port req_addr, input, NPORT*32: byte address.
REQ-013 SHALL have port req_size, input, NPORT*2: log2 of the byte count; must not exceed log2(NB).
REQ-014 SHALL have port req_signed, input, NPORT: sign-extend the read result.
REQ-015 SHALL have port req_wdata, input, NPORT*DATA_W: store data, little-endian.
REQ-016 SHALL have port resp_valid, output, NPORT: one-hot completion pulse.
REQ-017 SHALL have port resp_data, output, DATA_W: read result, shared across ports.
REQ-018 SHALL have port busy, output, 1: transaction in flight.
REQ-019 SHALL have port mem_din, input, 8: RAM read byte.
REQ-020 SHALL have port mem_dout, output, 8: RAM write byte.
REQ-021 SHALL have port mem_a, output, 32: RAM address.
REQ-022 SHALL have port mem_wr, output, 1: 1 = write, 0 = read.
REQ-023 SHALL have port io_buffer_full, input, 1: UART buffer full.

Function
REQ-024 SHALL implement FSM states IDLE, READ, WRITE, TURN, and SHALL serve one transaction at a time.
REQ-025 In IDLE, SHALL grant one valid port per edge and latch its addr, we, size, signed, wdata and port id.
- Fixed mode: lowest index wins.
- Round-robin mode: search starts at last granted index + 1, modulo NPORT.
REQ-026 SHALL ignore a port's later changes to req_valid or its request fields once that port is granted.
- A requester holds req_valid until its resp_valid pulse.
- Re-arbitration happens only in IDLE.
REQ-027 READ, n = 2^size bytes, granted at edge k:
- mem_a = addr+i during cycle k+i, for i = 0..n-1.
- Byte i is sampled from mem_din at edge k+i+1.
- resp_valid[id] is high for exactly the one cycle after edge k+n+1.
REQ-028 resp_data SHALL hold the assembled bytes, little-endian:
- sign-extended from bit 8n-1 if signed, else zero-extended;
- valid only while resp_valid is high;
- otherwise it holds its last value.
REQ-029 WRITE granted at edge k:
- mem_wr=1, mem_a=addr+i, mem_dout=wdata byte i during cycle k+i;
- after the last byte: mem_wr=0, mem_a=0, resp_valid[id] pulses for one cycle.
REQ-030 For a WRITE to an IO address while io_buffer_full=1:
- SHALL drive mem_wr=0 and hold the byte index;
- SHALL resume with the same byte once io_buffer_full=0.
- io_buffer_full SHALL NOT affect reads or non-IO writes.
REQ-031 After each completion, SHALL spend one TURN cycle with mem_wr=0 and mem_a=0, then return to IDLE.
- Back-to-back grants are therefore separated by one TURN cycle.
REQ-032 flush=1 during READ of a FLUSH_MASK port SHALL:
- abort at that edge with no resp_valid;
- set mem_a=0;
- go to TURN.
REQ-033 flush SHALL NOT abort a WRITE or a read from a non-masked port.
REQ-034 flush=1 in IDLE SHALL suppress granting masked read requests that edge; writes remain eligible.
REQ-035 When rdy=0, SHALL hold every register and output unchanged, including mem_wr.
REQ-036 busy SHALL be 1 in READ or WRITE, else 0.

Reset
REQ-037 While rst=1, irrespective of rdy, SHALL set:
- state=IDLE, resp_valid=0, resp_data=0;
- mem_wr=0, mem_a=0, mem_dout=0;
- round-robin pointer=NPORT-1.
REQ-038 rst asserted mid-transaction SHALL abandon it with no resp_valid; a partial write leaves earlier bytes written.

Verification
REQ-039 SHALL verify: port 1 LW, signed=0, addr 0x100, RAM holds 0x78,0x56,0x34,0x12 at 0x100..0x103 -> resp_data 0x12345678, resp_valid[1] pulses after edge k+5.
REQ-040 SHALL verify: LB signed=1 from a byte 0x80 -> 0xFFFFFF80; LB signed=0 from 0x80 -> 0x00000080.
REQ-041 SHALL verify: SH wdata 0xBEEF to 0x200 -> mem writes 0xEF@0x200 then 0xBE@0x201, then mem_wr=0 and resp_valid.
REQ-042 SHALL verify: SB to 0x30000 with io_buffer_full=1 for 5 cycles -> no mem_wr for 5 cycles, then a single write; a concurrent read from another port waits in the queue and is not blocked afterwards.
REQ-043 SHALL verify: ARB_RR=1, all 3 ports requesting continuously -> grant order 0,1,2,0; with ARB_RR=0 -> port 0 always wins.
REQ-044 SHALL verify: flush at the 2nd byte of a port-0 LW -> no resp_valid[0], TURN, then a pending port-2 SW is granted and completes.
